// File: rtl/gfx_pkg.sv
// Shared tile/framebuffer geometry, pixel word layout and flusher FSM states.
package gfx_pkg;

    localparam int unsigned TILE_W     = 80;
    localparam int unsigned TILE_H     = 10;
    localparam int unsigned FB_WIDTH   = 1280;
    localparam int unsigned FB_HEIGHT  = 720;

    typedef struct packed {
        logic [15:0] depth;
        logic [15:0] color;
    } pixel_word_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } flush_state_e;

    // Untouched pixels keep the cleared depth value and show the background.
    function automatic logic [15:0] map_color(input pixel_word_t word, input logic [15:0] bg);
        return (word.depth == 16'hFFFF) ? bg : word.color;
    endfunction

endpackage

// File: rtl/flush_fifo.sv
// Small synchronous FIFO with a registered first-word-fall-through output stage.
module flush_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  ring_cnt_q, ring_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             load, bypass, ring_wr, ring_rd;

    always_comb begin
        // The output register refills whenever it is empty or being drained this cycle.
        load       = !out_vld_q || out_ready;
        bypass     = load && (ring_cnt_q == '0) && in_valid;
        ring_wr    = in_valid && !bypass;
        ring_rd    = load && (ring_cnt_q != '0);
        wr_ptr_d   = ring_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = ring_rd ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        ring_cnt_d = ring_cnt_q + CntW'(ring_wr) - CntW'(ring_rd);
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (ring_rd) begin
            out_vld_d  = 1'b1;
            out_data_d = mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_vld_d  = 1'b1;
            out_data_d = in_data;
        end else if (load) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ring_wr) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ring_cnt_q <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ring_cnt_q <= ring_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign count     = ring_cnt_q + CntW'(out_vld_q);

endmodule

// File: rtl/tile_flusher.sv
// Drains a painted tile from tile BRAM and streams (address, colour) beats to the framebuffer.
module tile_flusher
    import gfx_pkg::*;
#(
    parameter logic [15:0] BG_COLOR   = 16'h0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] x_offset,
    input  logic [9:0]  y_offset,
    output logic [9:0]  tile_bram_read_addr,
    input  logic [31:0] tile_bram_read_data,
    output logic [19:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ColW = $clog2(TILE_W);
    localparam int unsigned RowW = $clog2(TILE_H);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    flush_state_e    state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [9:0]      rd_addr_q, rd_addr_d;
    logic [10:0]     x_off_q, x_off_d;
    logic [9:0]      y_off_q, y_off_d;
    logic [1:0]      inflight_q, inflight_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            s1_vld_q, s1_vld_d, s1_inb_q, s1_inb_d;
    logic            s2_vld_q, s2_vld_d, s2_inb_q, s2_inb_d;
    logic [19:0]     s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;

    logic [CntW-1:0] fifo_count;
    logic [CntW:0]   occupancy;
    logic            issue, last_pix, push;
    logic [11:0]     x_abs;
    logic [10:0]     y_abs;
    logic [19:0]     pix_addr;
    pixel_word_t     rd_word;
    logic [35:0]     push_data, pop_data;

    always_comb begin
        // Credit rule: every outstanding read is guaranteed a FIFO slot on return.
        occupancy = (CntW+1)'(fifo_count) + (CntW+1)'(inflight_q);
        issue     = (state_q == StRead) && (occupancy < (CntW+1)'(FIFO_DEPTH));
        last_pix  = (col_q == ColW'(TILE_W - 1)) && (row_q == RowW'(TILE_H - 1));
        x_abs     = 12'(x_off_q) + 12'(col_q);
        y_abs     = 11'(y_off_q) + 11'(row_q);
        pix_addr  = 20'(y_abs) * 20'(FB_WIDTH) + 20'(x_abs);
        rd_word   = tile_bram_read_data;
        push      = s2_vld_q && s2_inb_q;
        push_data = {s2_addr_q, map_color(rd_word, BG_COLOR)};

        s1_vld_d  = issue;
        s1_addr_d = pix_addr;
        s1_inb_d  = (x_abs < 12'(FB_WIDTH)) && (y_abs < 11'(FB_HEIGHT));
        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        s2_inb_d  = s1_inb_q;

        unique case ({issue, s2_vld_q})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        rd_addr_d = rd_addr_q;
        x_off_d   = x_off_q;
        y_off_d   = y_off_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_off_d   = x_offset;
                    y_off_d   = y_offset;
                    col_d     = '0;
                    row_d     = '0;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = StRead;
                end
            end
            StRead: begin
                if (issue) begin
                    rd_addr_d = last_pix ? 10'd0 : rd_addr_q + 10'd1;
                    if (col_q == ColW'(TILE_W - 1)) begin
                        col_d = '0;
                        row_d = last_pix ? '0 : row_q + RowW'(1);
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                    if (last_pix) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (inflight_q == 2'd0 && fifo_count == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            rd_addr_q  <= '0;
            x_off_q    <= '0;
            y_off_q    <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_inb_q   <= 1'b0;
            s1_addr_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_inb_q   <= 1'b0;
            s2_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rd_addr_q  <= rd_addr_d;
            x_off_q    <= x_off_d;
            y_off_q    <= y_off_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            s1_vld_q   <= s1_vld_d;
            s1_inb_q   <= s1_inb_d;
            s1_addr_q  <= s1_addr_d;
            s2_vld_q   <= s2_vld_d;
            s2_inb_q   <= s2_inb_d;
            s2_addr_q  <= s2_addr_d;
        end
    end

    flush_fifo #(
        .WIDTH (36),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   (push_data),
        .out_valid (fb_valid),
        .out_data  (pop_data),
        .out_ready (fb_ready),
        .count     (fifo_count)
    );

    assign tile_bram_read_addr = rd_addr_q;
    assign fb_addr             = pop_data[35:16];
    assign fb_data             = pop_data[15:0];
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_tile_flusher.sv
// Directed bench for tile_flusher: BRAM model, beat scoreboard and hand-computed spot checks.
module tb_tile_flusher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [10:0] x_offset = '0;
    logic [9:0]  y_offset = '0;
    logic [9:0]  tile_bram_read_addr;
    logic [31:0] tile_bram_read_data;
    logic [19:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_valid;
    logic        fb_ready = 1'b1;
    logic        busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [1024];
    logic [31:0] d1, d2;
    logic [35:0] exp_q [$];
    logic [19:0] got_addr [800];
    logic [15:0] got_data [800];
    int          beats = 0;
    bit          rand_ready = 1'b0;
    bit          occ_chk = 1'b0;
    bit          prev_stall = 1'b0;
    logic [35:0] prev_beat;

    always #5 clk = ~clk;

    tile_flusher #(
        .BG_COLOR   (16'hF800),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .x_offset            (x_offset),
        .y_offset            (y_offset),
        .tile_bram_read_addr (tile_bram_read_addr),
        .tile_bram_read_data (tile_bram_read_data),
        .fb_addr             (fb_addr),
        .fb_data             (fb_data),
        .fb_valid            (fb_valid),
        .fb_ready            (fb_ready),
        .busy                (busy),
        .done                (done)
    );

    always @(posedge clk) begin
        d1 <= mem[tile_bram_read_addr];
        d2 <= d1;
    end
    assign tile_bram_read_data = d2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs only change on posedge, so the negedge view is what the next edge will see.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold", {fb_valid, fb_addr, fb_data}, {1'b1, prev_beat});
            end
            fb_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (occ_chk) begin
                check("occupancy_le4",
                      64'(int'(dut.inflight_q) + int'(dut.fifo_count) <= 4), 64'd1);
            end
            if (fb_valid && fb_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {fb_addr, fb_data}, 36'd0);
                end else begin
                    check("beat", {fb_addr, fb_data}, exp_q.pop_front());
                end
                if (beats < 800) begin
                    got_addr[beats] = fb_addr;
                    got_data[beats] = fb_data;
                end
                beats++;
            end
            prev_stall = fb_valid && !fb_ready;
            prev_beat  = {fb_addr, fb_data};
        end
    end

    task automatic fill_mem();
        for (int n = 0; n < 1024; n++) begin
            mem[n] = {16'h0001, 16'(n)};
        end
    endtask

    task automatic build_exp(input int x, input int y);
        exp_q.delete();
        beats = 0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 80; c++) begin
                if (x + c < 1280 && y + r < 720) begin
                    logic [31:0] w;
                    logic [15:0] d;
                    w = mem[r * 80 + c];
                    d = (w[31:16] == 16'hFFFF) ? 16'hF800 : w[15:0];
                    exp_q.push_back({20'((y + r) * 1280 + x + c), d});
                end
            end
        end
    endtask

    // Returns in the cycle right after the accepted start edge (cycle count 1).
    task automatic start_tile(input int x, input int y);
        @(negedge clk);
        x_offset = 11'(x);
        y_offset = 10'(y);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output int n_done, output int n_first);
        int n;
        n       = base;
        n_done  = -1;
        n_first = -1;
        while (n < base + 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (fb_valid && n_first < 0) n_first = n;
            if (done) begin
                n_done = n;
                break;
            end
        end
        if (n_done < 0) check("done_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", {done, busy}, 2'b00);
    endtask

    int nd, nf;

    initial begin
        fill_mem();
        #23;
        check("rst_outputs", {tile_bram_read_addr, fb_addr, fb_data, fb_valid, busy, done}, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: in-bounds tile at (0,0), ready held high
        build_exp(0, 0);
        start_tile(0, 0);
        check("busy_after_start", busy, 1'b1);
        check("first_read_addr", tile_bram_read_addr, 10'd0);
        wait_done(1, nd, nf);
        check("t1_done_cycle", nd, 805);
        check("t1_first_valid", nf, 4);
        check("t1_beats", beats, 800);
        check("t1_last", {got_addr[799], got_data[799]}, {20'd11599, 16'd799});
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: one unpainted pixel maps to the background colour
        mem[5] = {16'hFFFF, 16'h1234};
        build_exp(0, 0);
        start_tile(0, 0);
        wait_done(1, nd, nf);
        check("t2_bg_pixel", got_data[5], 16'hF800);
        check("t2_neighbour", got_data[6], 16'd6);
        check("t2_beats", beats, 800);
        fill_mem();

        // 3: backpressure at ~30% ready duty
        rand_ready = 1'b1;
        occ_chk    = 1'b1;
        build_exp(0, 0);
        start_tile(0, 0);
        wait_done(1, nd, nf);
        rand_ready = 1'b0;
        occ_chk    = 1'b0;
        check("t3_beats", beats, 800);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: tile hanging off the right edge
        build_exp(1240, 710);
        start_tile(1240, 710);
        wait_done(1, nd, nf);
        check("t4_beats", beats, 400);
        check("t4_first_addr", got_addr[0], 20'd910040);
        check("t4_last_addr", got_addr[399], 20'd921599);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: reset mid-flush, then a clean flush at (80,0)
        build_exp(0, 0);
        start_tile(0, 0);
        for (int i = 0; i < 2000 && beats < 300; i++) begin
            @(posedge clk);
            #2;
        end
        check("t5_reached_300", beats >= 300, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_rst_drop", {fb_valid, busy, done}, 3'b000);
        check("t5_clean_count", {dut.inflight_q, dut.fifo_count}, '0);
        @(negedge clk);
        rst = 1'b1;
        build_exp(80, 0);
        start_tile(80, 0);
        wait_done(1, nd, nf);
        check("t5_first_addr", got_addr[0], 20'd80);
        check("t5_beats", beats, 800);
        check("t5_done_cycle", nd, 805);

        // 6: start while busy is ignored
        build_exp(0, 0);
        start_tile(0, 0);
        repeat (9) @(posedge clk);
        #1;
        x_offset = 11'd640;
        y_offset = 10'd360;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(11, nd, nf);
        check("t6_done_cycle", nd, 805);
        check("t6_beats", beats, 800);
        check("t6_last_addr", got_addr[799], 20'd11599);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
